density_bram_writer: RTL and testbench

- Write-side counterpart of the display's density read path.
- Accepts a raster-ordered stream of per-cell density words (9 lanes x 8 bit) from the fluid simulation.
- Writes each word into the display BRAM at linear address x + GRID_W*y. Barrier cells are encoded as all lanes 0xFF, the value the display renders as black.
- After reset, clears the whole BRAM to zero. Then serves one frame per start request.

---
 rtl/fluid_pkg.sv | 33 +++
 rtl/raster_counter.sv | 50 +++++
 rtl/density_bram_writer.sv | 151 +++++++++++++++
 tb/tb_density_bram_writer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fluid_pkg.sv
// Shared fluid-display definitions: grid geometry, density word layout,
// barrier encoding and the BRAM writer state encoding.
package fluid_pkg;

    localparam int unsigned GRID_W     = 205;
    localparam int unsigned GRID_H     = 154;
    localparam int unsigned BRAM_DEPTH = GRID_W * GRID_H;
    localparam int unsigned ADDR_W     = $clog2(BRAM_DEPTH);
    localparam int unsigned X_W        = $clog2(GRID_W);
    localparam int unsigned Y_W        = $clog2(GRID_H);
    localparam int unsigned LANES      = 9;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned DATA_W     = LANES * LANE_W;

    // Lane value the display renders as black (barrier).
    localparam logic [LANE_W-1:0] BARRIER_LANE = 8'hFF;
    // Substitute lane-0 value that keeps saturated fluid from looking like a barrier.
    localparam logic [LANE_W-1:0] FLUID_CAP_LANE = 8'hFE;

    typedef logic [8:0][7:0] density_cell_t;

    typedef enum logic [1:0] {CLEAR, IDLE, STREAM, DONE} writer_state_t;

    // Density word with every lane set to the barrier value.
    function automatic density_cell_t barrier_cell();
        density_cell_t c;
        for (int unsigned i = 0; i < LANES; i++) begin
            c[i] = BARRIER_LANE;
        end
        return c;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order position tracker: linear address plus x/y, wrapping to the
// origin after the last cell. Shared between the density write and read paths.
module raster_counter
    import fluid_pkg::*;
#(
    parameter int unsigned COLS = GRID_W,
    parameter int unsigned ROWS = GRID_H,
    localparam int unsigned AW  = $clog2(COLS * ROWS),
    localparam int unsigned XW  = $clog2(COLS),
    localparam int unsigned YW  = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_c
);

    logic x_last_c;

    assign last_c   = (addr == AW'(COLS * ROWS - 1));
    assign x_last_c = (x == XW'(COLS - 1));

    // Advance one cell per step; the last cell wraps everything back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr <= '0;
            x    <= '0;
            y    <= '0;
        end else if (step) begin
            if (last_c) begin
                addr <= '0;
                x    <= '0;
                y    <= '0;
            end else begin
                addr <= addr + AW'(1);
                if (x_last_c) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/density_bram_writer.sv
// Writes a raster-ordered stream of density cells into the display BRAM.
// Clears the whole BRAM after reset, then serves one frame per start request.
// Optional build macro BARRIER_GUARD_EN: forces a barrier border around the
// grid and keeps non-barrier cells from being encoded as barriers.
module density_bram_writer
    import fluid_pkg::*;
(
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic                cell_valid_in,
    input  density_cell_t       cell_data_in,
    input  logic                barrier_in,
    output logic                cell_ready_out,
    output logic                wr_en_out,
    output logic [ADDR_W-1:0]   wr_addr_out,
    output logic [DATA_W-1:0]   wr_data_out,
    output logic                busy_out,
    output logic                frame_done_out
);

    writer_state_t       state;
    writer_state_t       state_nxt;

    logic                hs_c;
    logic                cnt_clr_c;
    logic                cnt_step_c;
    logic [ADDR_W-1:0]   cnt_addr;
    logic [X_W-1:0]      cnt_x;
    logic [Y_W-1:0]      cnt_y;
    logic                cnt_last_c;

    density_cell_t       cell_wr_c;

    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                ready_d;
    logic                busy_d;
    logic                done_d;

    assign hs_c       = cell_valid_in && cell_ready_out;
    assign cnt_step_c = (state == CLEAR) || hs_c;
    assign cnt_clr_c  = (state == IDLE);

    raster_counter #(
        .COLS (GRID_W),
        .ROWS (GRID_H)
    ) u_raster_counter (
        .clk    (pixel_clk_in),
        .rst    (rst_in),
        .clr    (cnt_clr_c),
        .step   (cnt_step_c),
        .addr   (cnt_addr),
        .x      (cnt_x),
        .y      (cnt_y),
        .last_c (cnt_last_c)
    );

    // State register.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: clear sweep, wait for start, stream one frame, finish.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt_last_c)         state_nxt = IDLE;
            IDLE:    if (start_in)           state_nxt = STREAM;
            STREAM:  if (hs_c && cnt_last_c) state_nxt = DONE;
            DONE:                            state_nxt = IDLE;
            default:                         state_nxt = CLEAR;
        endcase
    end

`ifdef BARRIER_GUARD_EN
    logic on_border_c;

    assign on_border_c = (cnt_x == '0) || (cnt_x == X_W'(GRID_W - 1)) ||
                         (cnt_y == '0) || (cnt_y == Y_W'(GRID_H - 1));

    // Border cells become barriers; saturated fluid gets lane 0 pulled off 0xFF.
    always_comb begin
        cell_wr_c = cell_data_in;
        if (barrier_in || on_border_c) begin
            cell_wr_c = barrier_cell();
        end else if (cell_data_in == barrier_cell()) begin
            cell_wr_c[0] = FLUID_CAP_LANE;
        end
    end
`else
    logic grid_pos_unused;

    assign grid_pos_unused = ^{cnt_x, cnt_y};

    // Barrier flag alone selects the black encoding.
    always_comb begin
        cell_wr_c = barrier_in ? barrier_cell() : cell_data_in;
    end
`endif

    // Output decode: next values of the registered BRAM port and status flags.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_out;
        wr_data_d = wr_data_out;
        ready_d   = (state_nxt == STREAM);
        busy_d    = (state_nxt == CLEAR) || (state_nxt == STREAM);
        done_d    = (state == DONE);
        case (state)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_addr;
                wr_data_d = '0;
            end
            STREAM: begin
                if (hs_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_addr;
                    wr_data_d = cell_wr_c;
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset drops any pending write.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            cell_ready_out <= 1'b0;
            busy_out       <= 1'b1;
            frame_done_out <= 1'b0;
        end else begin
            wr_en_out      <= wr_en_d;
            wr_addr_out    <= wr_addr_d;
            wr_data_out    <= wr_data_d;
            cell_ready_out <= ready_d;
            busy_out       <= busy_d;
            frame_done_out <= done_d;
        end
    end

endmodule

// File: tb/tb_density_bram_writer.sv
// Scoreboard bench for density_bram_writer: expected BRAM writes are queued
// when a cell is accepted and checked by an independent write monitor.
module tb_density_bram_writer;
    import fluid_pkg::*;

    logic                pixel_clk_in = 1'b0;
    logic                rst_in;
    logic                start_in;
    logic                cell_valid_in;
    density_cell_t       cell_data_in;
    logic                barrier_in;
    logic                cell_ready_out;
    logic                wr_en_out;
    logic [ADDR_W-1:0]   wr_addr_out;
    logic [DATA_W-1:0]   wr_data_out;
    logic                busy_out;
    logic                frame_done_out;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                n_checks = 0;
    int                n_fail   = 0;
    int                done_cnt = 0;
    bit                mon_en   = 1'b0;
    logic [DATA_W-1:0] cap_625  = '0;
    logic [DATA_W-1:0] cap_1030 = '0;

    density_bram_writer dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .cell_valid_in  (cell_valid_in),
        .cell_data_in   (cell_data_in),
        .barrier_in     (barrier_in),
        .cell_ready_out (cell_ready_out),
        .wr_en_out      (wr_en_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: position from the linear address, then the barrier rules.
    function automatic logic [DATA_W-1:0] model_write(input int unsigned addr, input density_cell_t d, input bit b);
        int unsigned   col;
        int unsigned   row;
        density_cell_t full_ff;
        density_cell_t r;
        col     = addr % GRID_W;
        row     = addr / GRID_W;
        full_ff = '1;
        r       = d;
`ifdef BARRIER_GUARD_EN
        if (b || col == 0 || col == GRID_W - 1 || row == 0 || row == GRID_H - 1)
            r = full_ff;
        else if (d == full_ff)
            r[0] = 8'hFE;
`else
        if (b) r = full_ff;
        if (col > GRID_W || row > GRID_H) r = '0;
`endif
        return r;
    endfunction

    task automatic push_exp(input int unsigned addr, input logic [DATA_W-1:0] data);
        exp_t e;
        e.addr = ADDR_W'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every BRAM write must match the oldest expected write.
    always @(negedge pixel_clk_in) begin
        if (frame_done_out) done_cnt++;
        if (mon_en && wr_en_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr_out, wr_data_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", DATA_W'(wr_addr_out), DATA_W'(mon_e.addr));
                check("wr_data", wr_data_out, mon_e.data);
                if (mon_e.data != '0 && mon_e.addr == ADDR_W'(625))  cap_625  = wr_data_out;
                if (mon_e.data != '0 && mon_e.addr == ADDR_W'(1030)) cap_1030 = wr_data_out;
            end
        end
    end

    // Drive cells from the current negedge; an accept is seen as valid && ready
    // while ready is stable, so the write is expected one clock later.
    task automatic drive_cells(input int n_cells, input int gap_cells, output int accepted);
        int            i;
        int            budget;
        density_cell_t d;
        bit            b;
        i      = 0;
        budget = n_cells + 2 * gap_cells + 200;
        while (i < n_cells && budget > 0) begin
            if (i == 625) begin
                for (int k = 0; k < 9; k++) d[k] = 8'h11;
                b = 1'b1;
            end else if (i == 1030) begin
                d = '1;
                b = 1'b0;
            end else begin
                for (int k = 0; k < 9; k++) d[k] = 8'($urandom);
                b = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 31) == 0) d = '1;
            end
            cell_data_in  = d;
            barrier_in    = b;
            cell_valid_in = (i >= gap_cells) || ($urandom_range(0, 9) >= 3);
            start_in      = ($urandom_range(0, 7) == 0);
            if (cell_valid_in && cell_ready_out) begin
                push_exp(i, model_write(i, d, b));
                i++;
            end
            @(negedge pixel_clk_in);
            budget--;
        end
        cell_valid_in = 1'b0;
        start_in      = 1'b0;
        barrier_in    = 1'b0;
        accepted      = i;
    endtask

    initial begin
        int            run;
        bit            seen;
        int            acc;
        density_cell_t ff_cell;
        density_cell_t guard_cell;

        rst_in        = 1'b1;
        start_in      = 1'b0;
        cell_valid_in = 1'b0;
        cell_data_in  = '0;
        barrier_in    = 1'b0;
        ff_cell       = '1;
        guard_cell    = '1;
`ifdef BARRIER_GUARD_EN
        guard_cell[0] = 8'hFE;
`endif

        // Reset held for two clocks.
        @(negedge pixel_clk_in);
        @(negedge pixel_clk_in);
        check("rst_wr_en", DATA_W'(wr_en_out), '0);
        check("rst_wr_addr", DATA_W'(wr_addr_out), '0);
        check("rst_wr_data", wr_data_out, '0);
        check("rst_ready", DATA_W'(cell_ready_out), '0);
        check("rst_busy", DATA_W'(busy_out), DATA_W'(1));
        check("rst_frame_done", DATA_W'(frame_done_out), '0);

        // Power-up clear sweep.
        rst_in = 1'b0;
        mon_en = 1'b1;
        for (int a = 0; a < int'(BRAM_DEPTH); a++) push_exp(a, '0);
        run  = 0;
        seen = 1'b0;
        for (int c = 0; c < int'(BRAM_DEPTH) + 20; c++) begin
            @(negedge pixel_clk_in);
            if (wr_en_out) begin
                run++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("clear_run_length", DATA_W'(run), DATA_W'(BRAM_DEPTH));
        check("clear_busy_fall", DATA_W'(busy_out), '0);
        check("clear_no_done", DATA_W'(done_cnt), '0);
        check("clear_drained", DATA_W'(exp_q.size()), '0);
        check("idle_ready", DATA_W'(cell_ready_out), '0);

        // Frame 1: full frame, random gaps on the first 2000 cells.
        start_in = 1'b1;
        @(negedge pixel_clk_in);
        start_in = 1'b0;
        check("stream_ready", DATA_W'(cell_ready_out), DATA_W'(1));
        check("stream_busy", DATA_W'(busy_out), DATA_W'(1));
        drive_cells(int'(BRAM_DEPTH), 2000, acc);
        check("frame1_accepted", DATA_W'(acc), DATA_W'(BRAM_DEPTH));
        check("ready_after_last", DATA_W'(cell_ready_out), '0);
        check("final_write_in_done", DATA_W'(wr_en_out), DATA_W'(1));
        check("done_not_early", DATA_W'(frame_done_out), '0);
        @(negedge pixel_clk_in);
        check("frame_done_pulse", DATA_W'(frame_done_out), DATA_W'(1));
        check("busy_after_frame", DATA_W'(busy_out), '0);
        repeat (5) @(negedge pixel_clk_in);
        check("start_not_queued", DATA_W'(cell_ready_out), '0);
        check("frame1_drained", DATA_W'(exp_q.size()), '0);
        check("frame1_done_count", DATA_W'(done_cnt), DATA_W'(1));
        check("barrier_cell_625", cap_625, ff_cell);
        check("saturated_cell_1030", cap_1030, guard_cell);

        // Frame 2: abort with reset after 1000 accepted cells.
        start_in = 1'b1;
        @(negedge pixel_clk_in);
        start_in = 1'b0;
        check("stream2_ready", DATA_W'(cell_ready_out), DATA_W'(1));
        drive_cells(1000, 1000, acc);
        check("frame2_accepted", DATA_W'(acc), DATA_W'(1000));
        rst_in = 1'b1;
        @(negedge pixel_clk_in);
        check("abort_no_write", DATA_W'(wr_en_out), '0);
        check("abort_busy", DATA_W'(busy_out), DATA_W'(1));
        check("abort_ready", DATA_W'(cell_ready_out), '0);
        check("abort_pending_dropped", DATA_W'(exp_q.size()), '0);
        rst_in = 1'b0;
        for (int a = 0; a < 1200; a++) push_exp(a, '0);
        for (int c = 0; c < 1500 && exp_q.size() != 0; c++) @(posedge pixel_clk_in);
        mon_en = 1'b0;
        check("reclear_drained", DATA_W'(exp_q.size()), '0);
        check("abort_no_done", DATA_W'(done_cnt), DATA_W'(1));
        check("reclear_busy", DATA_W'(busy_out), DATA_W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
